// File: rtl/triangle_pkg.sv
// Shared types and constants for the triangle rasterizer host.
// Holds the host FSM state encoding and the layout of the packed
// triangle command word {x2,y2,x1,y1,x0,y0} (y0 at the LSBs).
package triangle_pkg;

  // Default coordinate width; the bitmap is 2^COORD_W x 2^COORD_W.
  localparam int COORD_W_DEFAULT = 3;

  // Width of the packed three-vertex command at the default coordinate width.
  localparam int CMD_W = 6 * COORD_W_DEFAULT;

  // Field index of each coordinate inside cmd_xy, in units of COORD_W bits.
  localparam int Y0_FIELD = 0;
  localparam int X0_FIELD = 1;
  localparam int Y1_FIELD = 2;
  localparam int X1_FIELD = 3;
  localparam int Y2_FIELD = 4;
  localparam int X2_FIELD = 5;

  // Host sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND0     = 3'd1,
    ST_SEND1     = 3'd2,
    ST_SEND2     = 3'd3,
    ST_WAIT_BUSY = 3'd4,
    ST_COLLECT   = 3'd5,
    ST_DONE      = 3'd6
  } tri_host_state_t;

endpackage

// File: rtl/tri_bitmap.sv
// Pixel occupancy bitmap: one bit per {y,x} address.
// Synchronous clear, single set port that also reports whether the bit
// was still zero (for unique-pixel counting), and a registered read port
// that returns the pre-update value on a same-cycle read/set collision.
module tri_bitmap #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  output logic              set_was_zero,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] bits_q, bits_d;
  logic             rd_data_q, rd_data_d;

  assign set_was_zero = ~bits_q[set_addr];
  assign rd_data      = rd_data_q;

  // Next bitmap contents and read data; the read samples the current bits.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing branch would infer a latch.
    bits_d    = bits_q;
    rd_data_d = bits_q[rd_addr];
    if (clr) begin
      bits_d = '0;
    end else if (set_en) begin
      bits_d[set_addr] = 1'b1;
    end
  end

  // Bitmap and read register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (reset) begin
      // NOTE: this storage is flops, not RAM, and must read back all-zero after reset, so it is reset explicitly.
      bits_q    <= '0;
      rd_data_q <= 1'b0;
    end else begin
      bits_q    <= bits_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: rtl/triangle_host.sv
// Command-side driver and pixel collector for the triangle rasterizer.
// Accepts one triangle command, serialises its three vertices onto nt/xi/yi,
// follows the rasterizer's busy handshake and records every emitted point
// into an occupancy bitmap with a unique-pixel count.
// Optional feature: define TRIANGLE_HOST_TIMEOUT_EN to add a cycle budget
// (TIMEOUT) over WAIT_BUSY+COLLECT that aborts to DONE and raises err.
module triangle_host
  import triangle_pkg::*;
#(
  parameter int COORD_W   = COORD_W_DEFAULT,
  parameter int BUSY_WAIT = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [6*COORD_W-1:0] cmd_xy,
  output logic                 nt,
  output logic [COORD_W-1:0]   xi,
  output logic [COORD_W-1:0]   yi,
  input  logic                 busy,
  input  logic                 po,
  input  logic [COORD_W-1:0]   xo,
  input  logic [COORD_W-1:0]   yo,
  output logic                 done,
  output logic                 err,
  output logic [2*COORD_W:0]   pix_count,
  input  logic [2*COORD_W-1:0] rd_addr,
  output logic                 rd_data
);

  localparam int ADDR_W   = 2 * COORD_W;
  localparam int PIX_W    = ADDR_W + 1;
  localparam int WAIT_W   = $clog2(BUSY_WAIT + 1);
  localparam int V12_BASE = Y1_FIELD * COORD_W;
  localparam int V12_W    = 4 * COORD_W;

  localparam logic [PIX_W-1:0]  PIX_MAX   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_WAIT - 1);

  tri_host_state_t      state_q, state_d;
  logic [V12_W-1:0]     vtx12_q, vtx12_d;   // v1 and v2 of the accepted command
  logic                 nt_q, nt_d;
  logic [COORD_W-1:0]   xi_q, xi_d;
  logic [COORD_W-1:0]   yi_q, yi_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [PIX_W-1:0]     pix_count_q, pix_count_d;

  logic                 accept;
  logic                 in_run;
  logic                 cap_en;
  logic                 cap_new;
  logic                 tmo_hit;

  logic [COORD_W-1:0]   v0_x, v0_y, v1_x, v1_y, v2_x, v2_y;

  assign v0_x = cmd_xy[X0_FIELD*COORD_W +: COORD_W];
  assign v0_y = cmd_xy[Y0_FIELD*COORD_W +: COORD_W];
  assign v1_x = vtx12_q[X1_FIELD*COORD_W - V12_BASE +: COORD_W];
  assign v1_y = vtx12_q[Y1_FIELD*COORD_W - V12_BASE +: COORD_W];
  assign v2_x = vtx12_q[X2_FIELD*COORD_W - V12_BASE +: COORD_W];
  assign v2_y = vtx12_q[Y2_FIELD*COORD_W - V12_BASE +: COORD_W];

  // Ready is held low while reset is asserted even though the state is IDLE.
  assign cmd_ready = (state_q == ST_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign in_run    = (state_q == ST_WAIT_BUSY) || (state_q == ST_COLLECT);
  assign cap_en    = po && in_run;

  assign nt        = nt_q;
  assign xi        = xi_q;
  assign yi        = yi_q;
  assign done      = (state_q == ST_DONE);
  assign pix_count = pix_count_q;

  tri_bitmap #(
    .ADDR_W(ADDR_W)
  ) u_bitmap (
    .clk         (clk),
    .reset       (reset),
    .clr         (accept),
    .set_en      (cap_en),
    .set_addr    ({yo, xo}),
    .set_was_zero(cap_new),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

`ifdef TRIANGLE_HOST_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  // Only consulted in WAIT_BUSY/COLLECT; the counter restarts on the way in.
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT));
  assign err     = err_q;

  // Run-time budget counter and sticky error flag.
  always_comb begin
    tmo_d = tmo_q;
    err_d = err_q;
    if (state_q == ST_SEND2) begin
      tmo_d = '0;
    end else if (in_run && !tmo_hit) begin
      tmo_d = tmo_q + 1'b1;
    end
    if (accept) begin
      err_d = 1'b0;
    end else if (in_run && tmo_hit) begin
      err_d = 1'b1;
    end
  end

  // Timeout registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
`else
  logic unused_timeout;

  assign tmo_hit        = 1'b0;
  assign err            = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Sequencing FSM, vertex bus, busy-wait counter and unique-pixel counter.
  always_comb begin
    state_d     = state_q;
    vtx12_d     = vtx12_q;
    nt_d        = 1'b0;
    xi_d        = xi_q;
    yi_d        = yi_q;
    wait_d      = wait_q;
    pix_count_d = pix_count_q;

    // The vertex bus is registered, so each state loads what the next one shows.
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          vtx12_d = cmd_xy[V12_BASE +: V12_W];
          nt_d    = 1'b1;
          xi_d    = v0_x;
          yi_d    = v0_y;
          state_d = ST_SEND0;
        end
      end
      ST_SEND0: begin
        xi_d    = v1_x;
        yi_d    = v1_y;
        state_d = ST_SEND1;
      end
      ST_SEND1: begin
        xi_d    = v2_x;
        yi_d    = v2_y;
        state_d = ST_SEND2;
      end
      ST_SEND2: begin
        wait_d  = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // busy rising wins over the wait limit on the same cycle.
        if (tmo_hit) begin
          state_d = ST_DONE;
        end else if (busy) begin
          state_d = ST_COLLECT;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_COLLECT: begin
        if (tmo_hit || !busy) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      pix_count_d = '0;
    end else if (cap_en && cap_new && (pix_count_q != PIX_MAX)) begin
      pix_count_d = pix_count_q + 1'b1;
    end
  end

  // Host registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      vtx12_q     <= '0;
      nt_q        <= 1'b0;
      xi_q        <= '0;
      yi_q        <= '0;
      wait_q      <= '0;
      pix_count_q <= '0;
    end else begin
      state_q     <= state_d;
      vtx12_q     <= vtx12_d;
      nt_q        <= nt_d;
      xi_q        <= xi_d;
      yi_q        <= yi_d;
      wait_q      <= wait_d;
      pix_count_q <= pix_count_d;
    end
  end

endmodule
